// File: rtl/video_pixel_unpack_if.sv
// Stream bundle for video_pixel_unpack: packed-word input side (m_axis_vid_*)
// and unpacked-pixel output side (s_axis_vid_*).
interface video_pixel_unpack_if;
  logic [31:0] m_axis_vid_tdata;
  logic        m_axis_vid_tvalid;
  logic        m_axis_vid_tready;
  logic        m_axis_vid_tuser;
  logic        m_axis_vid_tlast;
  logic [31:0] s_axis_vid_tdata;
  logic        s_axis_vid_tvalid;
  logic        s_axis_vid_tready;
  logic        s_axis_vid_tuser;
  logic        s_axis_vid_tlast;

  // Unpacker side: consumes words, produces pixels.
  modport slave (
    input  m_axis_vid_tdata, m_axis_vid_tvalid, m_axis_vid_tuser, m_axis_vid_tlast,
    input  s_axis_vid_tready,
    output m_axis_vid_tready,
    output s_axis_vid_tdata, s_axis_vid_tvalid, s_axis_vid_tuser, s_axis_vid_tlast
  );

  // Surrounding logic: DMA word source and pixel sink.
  modport master (
    output m_axis_vid_tdata, m_axis_vid_tvalid, m_axis_vid_tuser, m_axis_vid_tlast,
    output s_axis_vid_tready,
    input  m_axis_vid_tready,
    input  s_axis_vid_tdata, s_axis_vid_tvalid, s_axis_vid_tuser, s_axis_vid_tlast
  );
endinterface

// File: rtl/video_pixel_unpack.sv
// Unpacks 32-bit framebuffer words into {R,G,B,fill} pixels (32bpp / RGB565 / GREY8).
// Define VIDEO_UNPACK_GREY8_EN to enable GREY8 decode; otherwise mode 2 decodes as 32bpp.
module video_pixel_unpack #(
  parameter logic [7:0] ALPHA_FILL = 8'h00,
  parameter int         HI_FIRST   = 0
) (
  input  logic                        m_axis_vid_aclk,
  input  logic                        m_axis_vid_areset,
  input  logic [1:0]                  mode,
  video_pixel_unpack_if.slave         vid
);

  logic [31:0] r_word;
  logic [1:0]  r_mode;
  logic [1:0]  r_idx;
  logic        r_tuser;
  logic        r_tlast;
  logic        r_full;

  logic [1:0]  w_last_idx;
  logic [1:0]  w_slot;
  logic        w_last_px;
  logic        w_m_ready;
  logic        w_in_fire;
  logic        w_out_fire;
  logic [15:0] w_half;
  logic [4:0]  w_r5;
  logic [5:0]  w_g6;
  logic [4:0]  w_b5;
  logic [31:0] w_pixel;
`ifdef VIDEO_UNPACK_GREY8_EN
  logic [7:0]  w_grey;
`endif

  // Index of the final pixel in the held word; decided by the mode latched with it.
  always_comb begin
    w_last_idx = 2'd0;
    case (r_mode)
      2'd1:    w_last_idx = 2'd1;
`ifdef VIDEO_UNPACK_GREY8_EN
      2'd2:    w_last_idx = 2'd3;
`endif
      default: w_last_idx = 2'd0;
    endcase
  end

  assign w_last_px  = (r_idx == w_last_idx);
  assign w_slot     = (HI_FIRST != 0) ? (w_last_idx - r_idx) : r_idx;

  // Refill in the same cycle the last held pixel leaves, so 32bpp streams at full rate.
  assign w_m_ready  = !r_full | (vid.s_axis_vid_tready & w_last_px);
  assign w_in_fire  = vid.m_axis_vid_tvalid & w_m_ready;
  assign w_out_fire = r_full & vid.s_axis_vid_tready;

  always_ff @(posedge m_axis_vid_aclk or posedge m_axis_vid_areset) begin
    if (m_axis_vid_areset) begin
      r_word  <= 32'h0;
      r_mode  <= 2'd0;
      r_idx   <= 2'd0;
      r_tuser <= 1'b0;
      r_tlast <= 1'b0;
      r_full  <= 1'b0;
    end else if (w_in_fire) begin
      r_word  <= vid.m_axis_vid_tdata;
      r_mode  <= mode;
      r_tuser <= vid.m_axis_vid_tuser;
      r_tlast <= vid.m_axis_vid_tlast;
      r_full  <= 1'b1;
      r_idx   <= 2'd0;
    end else if (w_out_fire) begin
      if (w_last_px) begin
        r_full <= 1'b0;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // RGB565 slots are only ever 0 or 1, so any nonzero slot picks the upper half.
  assign w_half = (w_slot != 2'd0) ? r_word[31:16] : r_word[15:0];
  assign w_r5   = w_half[4:0];
  assign w_g6   = w_half[10:5];
  assign w_b5   = w_half[15:11];
`ifdef VIDEO_UNPACK_GREY8_EN
  assign w_grey = r_word[{w_slot, 3'b000} +: 8];
`endif

  always_comb begin
    w_pixel = {r_word[23:0], ALPHA_FILL};
    case (r_mode)
      2'd1:    w_pixel = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2], ALPHA_FILL};
`ifdef VIDEO_UNPACK_GREY8_EN
      2'd2:    w_pixel = {w_grey, w_grey, w_grey, ALPHA_FILL};
`endif
      default: w_pixel = {r_word[23:0], ALPHA_FILL};
    endcase
  end

  assign vid.m_axis_vid_tready = w_m_ready;
  assign vid.s_axis_vid_tdata  = w_pixel;
  assign vid.s_axis_vid_tvalid = r_full;
  assign vid.s_axis_vid_tuser  = r_tuser & (r_idx == 2'd0);
  assign vid.s_axis_vid_tlast  = r_tlast & w_last_px;

endmodule

// File: tb/tb_video_pixel_unpack.sv
// Self-checking bench for video_pixel_unpack: two instances (LSB-first/fill 00 and
// MSB-first/fill 5A) share stimulus and are checked against a pixel-queue model.
module tb_video_pixel_unpack;

`ifdef VIDEO_UNPACK_GREY8_EN
  localparam bit GreyEn = 1'b1;
`else
  localparam bit GreyEn = 1'b0;
`endif
  localparam logic [7:0] Alpha1 = 8'h5A;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
  } pix_t;

  typedef struct {
    logic [1:0]       mode;
    logic [31:0]      word;
    int               n;
    logic [3:0][31:0] px;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mData = '0;
  logic [1:0]  mMode = '0;
  logic        mValid = 1'b0;
  logic        mUser = 1'b0;
  logic        mLast = 1'b0;
  logic        sReady = 1'b0;
  bit          toggleReady = 1'b0;

  int   nVectors = 0;
  int   nMiscompare = 0;
  pix_t q0[$];
  pix_t q1[$];
  vec_t vecs[$];

  video_pixel_unpack_if if0 ();
  video_pixel_unpack_if if1 ();

  assign if0.m_axis_vid_tdata  = mData;
  assign if0.m_axis_vid_tvalid = mValid;
  assign if0.m_axis_vid_tuser  = mUser;
  assign if0.m_axis_vid_tlast  = mLast;
  assign if0.s_axis_vid_tready = sReady;
  assign if1.m_axis_vid_tdata  = mData;
  assign if1.m_axis_vid_tvalid = mValid;
  assign if1.m_axis_vid_tuser  = mUser;
  assign if1.m_axis_vid_tlast  = mLast;
  assign if1.s_axis_vid_tready = sReady;

  video_pixel_unpack #(.ALPHA_FILL(8'h00), .HI_FIRST(0)) u_dut0 (
    .m_axis_vid_aclk   (clk),
    .m_axis_vid_areset (rst),
    .mode              (mMode),
    .vid               (if0.slave)
  );

  video_pixel_unpack #(.ALPHA_FILL(Alpha1), .HI_FIRST(1)) u_dut1 (
    .m_axis_vid_aclk   (clk),
    .m_axis_vid_areset (rst),
    .mode              (mMode),
    .vid               (if1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int pixPerWord(input logic [1:0] md);
    if (md == 2'd1) return 2;
    if (md == 2'd2 && GreyEn) return 4;
    return 1;
  endfunction

  // Pixel k (0 = least significant) of a word holding n pixels, by plain arithmetic.
  function automatic logic [31:0] pixelOf(input logic [31:0] w, input int n, input int k,
                                          input logic [7:0] alpha);
    int unsigned h, r, g, b, y, a;
    a = 32'(alpha);
    if (n == 1) return ((w & 32'h00FF_FFFF) << 8) | a;
    if (n == 2) begin
      h = (w >> (16 * k)) & 32'hFFFF;
      r = h % 32;
      g = (h / 32) % 64;
      b = h / 2048;
      return ((r * 8 + r / 4) << 24) | ((g * 4 + g / 16) << 16) | ((b * 8 + b / 4) << 8) | a;
    end
    y = (w >> (8 * k)) & 32'hFF;
    return y * 32'h0101_0100 | a;
  endfunction

  task automatic pushWord(input logic [31:0] w, input logic [1:0] md, input logic u, input logic l);
    int   n;
    pix_t p;
    n = pixPerWord(md);
    for (int j = 0; j < n; j++) begin
      p.user = u && (j == 0);
      p.last = l && (j == n - 1);
      p.data = pixelOf(w, n, j, 8'h00);
      q0.push_back(p);
      p.data = pixelOf(w, n, n - 1 - j, Alpha1);
      q1.push_back(p);
    end
  endtask

  task automatic checkOutput();
    logic expValid, expReady;
    expValid = (q0.size() > 0);
    expReady = (q0.size() == 0) || (sReady && q0.size() == 1);
    cmp("d0.s_tvalid", 32'(if0.s_axis_vid_tvalid), 32'(expValid));
    cmp("d1.s_tvalid", 32'(if1.s_axis_vid_tvalid), 32'(expValid));
    cmp("d0.m_tready", 32'(if0.m_axis_vid_tready), 32'(expReady));
    cmp("d1.m_tready", 32'(if1.m_axis_vid_tready), 32'(expReady));
    if (expValid) begin
      cmp("d0.s_tdata", if0.s_axis_vid_tdata, q0[0].data);
      cmp("d0.s_tuser", 32'(if0.s_axis_vid_tuser), 32'(q0[0].user));
      cmp("d0.s_tlast", 32'(if0.s_axis_vid_tlast), 32'(q0[0].last));
      cmp("d1.s_tdata", if1.s_axis_vid_tdata, q1[0].data);
      cmp("d1.s_tuser", 32'(if1.s_axis_vid_tuser), 32'(q1[0].user));
      cmp("d1.s_tlast", 32'(if1.s_axis_vid_tlast), 32'(q1[0].last));
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model with the edge.
  task automatic cycle(output bit accepted);
    bit outFire, inFire;
    if (toggleReady) sReady = ~sReady;
    #3;
    checkOutput();
    outFire = (q0.size() > 0) && sReady;
    inFire  = mValid && ((q0.size() == 0) || (sReady && q0.size() == 1));
    @(posedge clk);
    if (outFire) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (inFire) pushWord(mData, mMode, mUser, mLast);
    accepted = inFire;
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic [1:0] md, input logic u, input logic l);
    bit acc;
    acc    = 1'b0;
    mData  = w;
    mMode  = md;
    mUser  = u;
    mLast  = l;
    mValid = 1'b1;
    for (int t = 0; t < 32 && !acc; t++) cycle(acc);
    if (!acc) begin
      nVectors++;
      nMiscompare++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept of %h", w);
    end
  endtask

  task automatic drain();
    bit acc;
    mValid      = 1'b0;
    toggleReady = 1'b0;
    sReady      = 1'b1;
    for (int t = 0; t < 16 && q0.size() > 0; t++) cycle(acc);
  endtask

  task automatic checkResetOutputs(input string tag);
    cmp({tag, ".d0.tvalid"}, 32'(if0.s_axis_vid_tvalid), 32'd0);
    cmp({tag, ".d0.tdata"},  if0.s_axis_vid_tdata, 32'h0000_0000);
    cmp({tag, ".d0.tuser"},  32'(if0.s_axis_vid_tuser), 32'd0);
    cmp({tag, ".d0.tlast"},  32'(if0.s_axis_vid_tlast), 32'd0);
    cmp({tag, ".d0.tready"}, 32'(if0.m_axis_vid_tready), 32'd1);
    cmp({tag, ".d1.tvalid"}, 32'(if1.s_axis_vid_tvalid), 32'd0);
    cmp({tag, ".d1.tdata"},  if1.s_axis_vid_tdata, {24'h0, Alpha1});
  endtask

  task automatic addVec(input logic [1:0] md, input logic [31:0] w, input int n,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3);
    vec_t v;
    v.mode  = md;
    v.word  = w;
    v.n     = n;
    v.px[0] = p0;
    v.px[1] = p1;
    v.px[2] = p2;
    v.px[3] = p3;
    vecs.push_back(v);
  endtask

  initial begin
    bit acc;

    // Hand-decoded vectors, LSB-first order with fill 00.
    addVec(2'd1, 32'hFFFF_0000, 2, 32'h0000_0000, 32'hFFFF_FF00, 32'h0, 32'h0);
    addVec(2'd1, 32'h0000_F81F, 2, 32'hFF00_FF00, 32'h0000_0000, 32'h0, 32'h0);
    addVec(2'd1, 32'h07E0_001F, 2, 32'hFF00_0000, 32'h00FF_0000, 32'h0, 32'h0);
    addVec(2'd1, 32'h8410_0842, 2, 32'h1008_0800, 32'h8482_8400, 32'h0, 32'h0);
    addVec(2'd0, 32'hAA11_2233, 1, 32'h1122_3300, 32'h0, 32'h0, 32'h0);
    addVec(2'd3, 32'hDEAD_BEEF, 1, 32'hADBE_EF00, 32'h0, 32'h0, 32'h0);
`ifdef VIDEO_UNPACK_GREY8_EN
    addVec(2'd2, 32'h4030_2010, 4, 32'h1010_1000, 32'h2020_2000, 32'h3030_3000, 32'h4040_4000);
`else
    addVec(2'd2, 32'h4030_2010, 1, 32'h3020_1000, 32'h0, 32'h0, 32'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    // Frame/line markers on a two-pixel word; input stalls for exactly one cycle.
    sReady = 1'b1;
    applyStimulus(32'hFFFF_0000, 2'd1, 1'b1, 1'b1);
    mValid = 1'b0;
    #2;
    cmp("seqA.px0.data",   if0.s_axis_vid_tdata, 32'h0000_0000);
    cmp("seqA.px0.tuser",  32'(if0.s_axis_vid_tuser), 32'd1);
    cmp("seqA.px0.tlast",  32'(if0.s_axis_vid_tlast), 32'd0);
    cmp("seqA.px0.tready", 32'(if0.m_axis_vid_tready), 32'd0);
    cmp("seqA.d1px0.data", if1.s_axis_vid_tdata, 32'hFFFF_FF5A);
    cycle(acc);
    #2;
    cmp("seqA.px1.data",   if0.s_axis_vid_tdata, 32'hFFFF_FF00);
    cmp("seqA.px1.tuser",  32'(if0.s_axis_vid_tuser), 32'd0);
    cmp("seqA.px1.tlast",  32'(if0.s_axis_vid_tlast), 32'd1);
    cmp("seqA.px1.tready", 32'(if0.m_axis_vid_tready), 32'd1);
    drain();

    // Table vectors, each drained with the sink always ready.
    foreach (vecs[i]) begin
      sReady = 1'b1;
      applyStimulus(vecs[i].word, vecs[i].mode, 1'b0, 1'b0);
      mValid = 1'b0;
      for (int j = 0; j < vecs[i].n; j++) begin
        #2;
        cmp($sformatf("tbl%0d.d0.px%0d", i, j), if0.s_axis_vid_tdata, vecs[i].px[j]);
        cmp($sformatf("tbl%0d.d1.px%0d", i, j), if1.s_axis_vid_tdata,
            {vecs[i].px[vecs[i].n - 1 - j][31:8], Alpha1});
        cycle(acc);
      end
      drain();
    end

    // 32bpp back-to-back at one word and one pixel per clock.
    sReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'hAA11_2233 + 32'(i), 2'd0, 1'b0, 1'b0);
      #2;
      cmp("b2b.px", if0.s_axis_vid_tdata, (32'h0011_2233 + 32'(i)) << 8);
      cmp("b2b.tready", 32'(if0.m_axis_vid_tready), 32'd1);
    end
    drain();

    // Sink ready toggling 1,0,1,0 on mode 2, with a second word waiting behind.
    sReady      = 1'b0;
    toggleReady = 1'b1;
    applyStimulus(32'h4030_2010, 2'd2, 1'b1, 1'b1);
    applyStimulus(32'h8070_6050, 2'd2, 1'b0, 1'b1);
    drain();

    // Mode changes to 32bpp while an RGB565 word is half consumed.
    sReady = 1'b1;
    applyStimulus(32'h8410_0842, 2'd1, 1'b0, 1'b0);
    mValid = 1'b0;
    cycle(acc);
    mMode = 2'd0;
    #2;
    cmp("modesw.px1", if0.s_axis_vid_tdata, 32'h8482_8400);
    applyStimulus(32'hAA11_2233, 2'd0, 1'b0, 1'b0);
    #2;
    cmp("modesw.next", if0.s_axis_vid_tdata, 32'h1122_3300);
    drain();

    // Reset after the first pixel drops the second one.
    applyStimulus(32'h0000_F81F, 2'd1, 1'b1, 1'b0);
    mValid = 1'b0;
    cycle(acc);
    rst = 1'b1;
    #1;
    checkResetOutputs("midrst");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(32'h8410_0842, 2'd1, 1'b1, 1'b1);
    mValid = 1'b0;
    #2;
    cmp("midrst.next.data",  if0.s_axis_vid_tdata, 32'h1008_0800);
    cmp("midrst.next.tuser", 32'(if0.s_axis_vid_tuser), 32'd1);
    cmp("midrst.d1.data",    if1.s_axis_vid_tdata, 32'h8482_845A);
    drain();

    // Randomized traffic; mode changes every cycle but only matters at accept.
    mValid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!mValid && $urandom_range(0, 2) != 0) begin
        mValid = 1'b1;
        mData  = $urandom;
        mUser  = ($urandom_range(0, 7) == 0);
        mLast  = ($urandom_range(0, 3) == 0);
      end
      mMode  = 2'($urandom_range(0, 3));
      sReady = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) mValid = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompare);
    $finish;
  end

endmodule

// File: doc/video_pixel_unpack.md
# video_pixel_unpack

AXI4-Stream pixel-format unpacker between the framebuffer read DMA and the video output pipeline. Accepts 32-bit packed words and emits one 32-bit {R,G,B,fill} pixel per output beat. Supports 32bpp passthrough, RGB565 (two pixels/word) and optional 8bpp grey (four pixels/word). Uses full ready/valid backpressure on both sides and propagates frame (tuser) and line (tlast) markers at pixel granularity.

## Interface
Parameters:
- ALPHA_FILL, 8'h00, value placed in output bits [7:0].
- HI_FIRST, 0, pixel order within a word: 0 = least-significant pixel first, 1 = most-significant first.

Ports:
- m_axis_vid_aclk  in  1  single clock for all logic.
- m_axis_vid_areset  in  1  reset, asynchronous, active-high.
- mode  in  2  format: 0 = 32bpp, 1 = RGB565, 2 = GREY8, 3 = reserved (treated as 32bpp).
- m_axis_vid_tdata  in  32  packed input word.
- m_axis_vid_tvalid  in  1  input word valid.
- m_axis_vid_tready  out  1  input accept.
- m_axis_vid_tuser  in  1  start of frame, on the first word of a frame.
- m_axis_vid_tlast  in  1  end of line, on the last word of a line.
- s_axis_vid_tdata  out  32  pixel {R[31:24],G[23:16],B[15:8],ALPHA_FILL}.
- s_axis_vid_tvalid  out  1  output pixel valid.
- s_axis_vid_tready  in  1  downstream accept.
- s_axis_vid_tuser  out  1  start of frame, on the first pixel only.
- s_axis_vid_tlast  out  1  end of line, on the last pixel only.

## Operation
- One-entry word holding register: word, mode, tuser, tlast, `full` flag, 2-bit pixel index `idx`.
- Pixels per word: N = 1 (32bpp/reserved), 2 (RGB565), 4 (GREY8). `last_px` = (idx == N-1).
- Input fire = m tvalid & m tready. Output fire = s tvalid & s tready.
- m_axis_vid_tready = !full | (s_axis_vid_tready & last_px). Combinational path from s tready is intentional.
- On input fire: load word, latch mode, tuser and tlast, set full, clear idx.
- On output fire without last_px: idx <= idx+1.
- On output fire with last_px and no input fire: full <= 0.
- On output fire with last_px and input fire in the same cycle: reload the register; full stays 1.
- `mode` is sampled only on input fire. Changing it mid-word does not affect the held word.
- Pixel slot k = HI_FIRST ? (N-1-idx) : idx.
- 32bpp: slot is the whole word. Output = {word[23:16], word[15:8], word[7:0], ALPHA_FILL}. word[31:24] is discarded.
- RGB565: h = word[16k+15 : 16k]. R5 = h[4:0], G6 = h[10:5], B5 = h[15:11].
- RGB565 expansion by MSB replication: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
- GREY8: g = word[8k+7 : 8k]. Output = {g, g, g, ALPHA_FILL}.
- s tuser = held tuser & (idx == 0). s tlast = held tlast & last_px.
- s_axis_vid_tdata is combinational from the holding register; no extra register stage.

## Timing
- Reset: full = 0, idx = 0, held word/flags = 0. Therefore s tvalid = 0, s tdata = {24'h0, ALPHA_FILL}, s tuser = 0, s tlast = 0, m tready = 1.
- Latency: first pixel valid on the cycle after input fire.
- Throughput: 1 pixel/clock with s tready held high.
- 32bpp: 1 word/clock.
- RGB565: 1 word per 2 clocks; GREY8: 1 word per 4 clocks.
- Backpressure: while s tready = 0, tdata/tuser/tlast/tvalid hold stable and idx does not advance.
- Reset asserted mid-word: held pixels are dropped and outputs return to reset values asynchronously. First input fire after deassertion starts at idx 0.

## Configuration
- VIDEO_UNPACK_GREY8_EN defined: mode 2 = GREY8 as above.
- VIDEO_UNPACK_GREY8_EN undefined: GREY8 logic is removed; mode 2 is treated as 32bpp (N = 1). idx never exceeds 1.

## Test plan
- Reset, then RGB565 word 32'hFFFF_0000 with tuser = 1, tlast = 1, HI_FIRST = 0, s tready = 1:
  - pixel 0 = 32'h0000_0000 with tuser = 1, tlast = 0;
  - pixel 1 = 32'hFFFF_FF00 with tuser = 0, tlast = 1;
  - m tready low for exactly 1 cycle.
- RGB565 word 32'h0000_F81F (low half R = 5'h1F, G = 0, B = 5'h1F) -> pixel 0 = 32'hFF00_FF00, pixel 1 = 32'h0000_0000.
  - Rerun with HI_FIRST = 1 -> the same two pixels in reverse order.
- 32bpp, 8 back-to-back words 32'hAA11_2233 + i, tready high -> 8 pixels on consecutive cycles; pixel i = {24'h11_2233 + i, 8'h00}; m tready constantly 1.
- GREY8 word 32'h40_30_20_10 with s tready toggling 1,0,1,0,… -> pixels 32'h1010_1000, 32'h2020_2000, 32'h3030_3000, 32'h4040_4000, each held stable across stall cycles. Next word accepted only in the cycle pixel 3 fires.
- Mode switch from 1 to 0 while an RGB565 word is half-consumed -> second pixel still decoded as RGB565; next word decoded as 32bpp.
- Reset asserted after the first pixel of an RGB565 word -> s tvalid = 0 immediately, second pixel never emitted. Next word's first pixel carries idx 0 and tuser as presented.
